// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRP*AW-1:0]     rd_addr,
    output logic [NRP*XLEN-1:0]   rd_data,
    output logic [NRP-1:0]        rd_busy,
    input  logic [NWP-1:0]        wr_en,
    input  logic [NWP*AW-1:0]     wr_addr,
    input  logic [NWP*XLEN-1:0]   wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    function automatic logic f_wr_hit(input logic [NWP-1:0]    en,
                                      input logic [NWP*AW-1:0] addr,
                                      input logic [AW-1:0]     a);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NWP; w++) begin
            if (en[w] && addr[w*AW +: AW] == a) hit = 1'b1;
        end
        return hit;
    endfunction

    // Later ports are applied last, so the highest-numbered port wins a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
                    r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // A fresh issue supersedes a retiring write to the same register.
    always_comb begin
        w_busy_nxt = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_busy_nxt[r] = (iss_en && iss_addr == AW'(r)) ||
                            (r_busy[r] && !f_wr_hit(wr_en, wr_addr, AW'(r)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    // Reads are forced to zero while reset is held, even with a bypass hit.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            if (rst_n && rd_addr[p*AW +: AW] != '0) begin
                rd_data[p*XLEN +: XLEN] = r_regs[rd_addr[p*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWP; w++) begin
                        if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
                            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    end
                end
            end
            rd_busy[p] = r_busy[rd_addr[p*AW +: AW]];
        end
    end

    assign busy_vec = r_busy;

endmodule
